panda_top_tb_wrap: RTL and testbench
====================================

# panda_top_tb_wrap

Position-capture (PCAP) arm/DMA/interrupt control core that sits between the Zynq PS register bus and the capture data stream at the top of the PandA carrier design. It accepts capture samples while armed and writes them to host buffers taken from a DMA address table. It raises interrupts carrying flags and a per-buffer sample count, and drives `pcap_armed` so the rest of the system can observe arm state.

## Interface
- `ADDR_DEPTH`, 32: DMA address-table entries (power of 2).
- `FCLK` in 1: sole clock.
- `ARESETn` in 1: asynchronous, active-low reset.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 4: register index.
- `wr_data` in 32: write data.
- `rd_en` in 1: register read strobe.
- `rd_addr` in 4: register index.
- `rd_data` out 32: read data, valid one cycle after `rd_en`.
- `smpl_valid` in 1: capture sample strobe.
- `smpl_data` in 32: capture sample.
- `frame_i` in 32: framing bits accompanying the sample.
- `dma_valid` out 1: DMA word write.
- `dma_addr` out 32: byte address.
- `dma_data` out 32: data word.
- `irq` out 1: interrupt, level.
- `pcap_armed` out 1: capture armed.

## Operation
- Registers:
  - 0 ARM: write any value to arm.
  - 1 DISARM: write any value to disarm.
  - 2 BLOCK_SIZE: samples per buffer, 16 bits, 0 treated as 1.
  - 3 DMA_ADDR: write pushes a buffer base into the address table FIFO.
  - 4 IRQ_STATUS: read returns {SMPL_COUNT[15:0], 8'h00, IRQ_FLAGS[7:0]}. Reading clears the flags and deasserts `irq`.
  - 5 FRAMING_MASK.
  - 6 TOTAL_SAMPLES: 32-bit count, read-only.
  - Unmapped reads return 0.
- State machine IDLE -> ARMED -> IDLE:
  - ARM in IDLE with the table non-empty: pop the first base, clear SMPL_COUNT and TOTAL_SAMPLES, enter ARMED.
  - ARM with the table empty: set flag bit2 (NO_ADDR) and stay IDLE.
  - ARM while already ARMED: ignored.
- ARMED:
  - Each accepted sample emits `dma_valid`, `dma_addr` = base + 4·SMPL_COUNT, and `dma_data` = `smpl_data`. It then increments SMPL_COUNT and TOTAL_SAMPLES.
  - When SMPL_COUNT reaches BLOCK_SIZE: set flag bit0 (BLOCK_DONE), latch SMPL_COUNT into the IRQ_STATUS count field, and pop the next base.
  - If no next base is available: set bit2 and bit1 (COMPLETED) and go to IDLE.
- DISARM in ARMED: latch the partial SMPL_COUNT, set bit1 and bit3 (USER_ABORT), go to IDLE.
- `irq` = OR of the flags.
- Address table is a FIFO of `ADDR_DEPTH` entries. A push when full is dropped and sets bit4 (TABLE_OVF).
- Flag bits 7:5 always read 0.

## Timing
- Reset values: all outputs 0, state IDLE, table empty, all registers 0, BLOCK_SIZE resets to 1.
- `pcap_armed` rises on the cycle after the ARM write and falls on the cycle after the terminating event.
- DMA latency: `dma_*` registered one cycle after `smpl_valid`.
- Samples presented in the ARM write cycle are ignored. A sample coinciding with the DISARM write is accepted.
- IRQ_STATUS read coinciding with a flag set: the new flag survives, and the read returns the pre-set value.
- Simultaneous DMA_ADDR push and internal pop: both proceed.
- `ARESETn` assertion mid-capture: immediate IDLE, and the table is flushed.

## Configuration
- `PCAP_FRAMING_EN` defined: a sample is accepted only when FRAMING_MASK == 0 or (`frame_i` & FRAMING_MASK) != 0.
- `PCAP_FRAMING_EN` undefined: every `smpl_valid` is accepted, register 5 reads 0, and `frame_i` is unused.

## Structure
- Shared package holds:
  - register index constants;
  - IRQ flag bit positions;
  - the state enum.
- One sub-module, `pcap_addr_fifo`: parameterised address-table FIFO providing push, pop, empty and full.

## Test plan
- Push bases 0x1000 and 0x2000, BLOCK_SIZE=4, ARM, then 8 samples. Required: DMA addresses 0x1000..0x100C then 0x2000..0x200C. Two BLOCK_DONE irqs, each with count 4. The second also sets COMPLETED and NO_ADDR, and `pcap_armed` falls.
- ARM with an empty table. Required: `pcap_armed` stays 0, IRQ_STATUS reads 0x00000004, and a second read returns 0.
- One base, BLOCK_SIZE=10, 3 samples, DISARM. Required: IRQ_STATUS = 0x0003000A and TOTAL_SAMPLES = 3.
- Push 33 bases with `ADDR_DEPTH`=32. Required: TABLE_OVF set and exactly 32 bases consumed.
- With `PCAP_FRAMING_EN` and FRAMING_MASK=0x1, send frame_i values 0,1,0,1. Required: only 2 DMA writes.
- Assert reset mid-capture. Required: all outputs 0 and the next ARM without a push sets NO_ADDR.

Source files
------------

// File: rtl/panda_top_tb_wrap_pkg.sv
// Shared definitions for the PCAP control core: register map, IRQ flag
// bit positions and the capture state encoding.
package panda_top_tb_wrap_pkg;

    localparam logic [3:0] REG_ARM           = 4'd0;
    localparam logic [3:0] REG_DISARM        = 4'd1;
    localparam logic [3:0] REG_BLOCK_SIZE    = 4'd2;
    localparam logic [3:0] REG_DMA_ADDR      = 4'd3;
    localparam logic [3:0] REG_IRQ_STATUS    = 4'd4;
    localparam logic [3:0] REG_FRAMING_MASK  = 4'd5;
    localparam logic [3:0] REG_TOTAL_SAMPLES = 4'd6;

    localparam int FLAG_BLOCK_DONE = 0;
    localparam int FLAG_COMPLETED  = 1;
    localparam int FLAG_NO_ADDR    = 2;
    localparam int FLAG_USER_ABORT = 3;
    localparam int FLAG_TABLE_OVF  = 4;
    localparam int FLAG_W          = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } pcap_state_e;

    // A block size of zero behaves as a single-sample block.
    function automatic logic [15:0] eff_block_size(input logic [15:0] bs);
        return (bs == 16'd0) ? 16'd1 : bs;
    endfunction

endpackage

// File: rtl/pcap_addr_fifo.sv
// DMA buffer-base table: FIFO with a registered head that holds the most
// recently popped entry, which is the base of the buffer being filled.
module pcap_addr_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] head_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = head_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                head_q   <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/panda_top_tb_wrap.sv
// PCAP arm/DMA/interrupt control core. Optional sample gating by frame bits
// is compiled in when PCAP_FRAMING_EN is defined.
module panda_top_tb_wrap
    import panda_top_tb_wrap_pkg::*;
#(
    parameter int ADDR_DEPTH = 32
) (
    input  logic        FCLK,
    input  logic        ARESETn,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        smpl_valid,
    input  logic [31:0] smpl_data,
    input  logic [31:0] frame_i,
    output logic        dma_valid,
    output logic [31:0] dma_addr,
    output logic [31:0] dma_data,
    output logic        irq,
    output logic        pcap_armed
);
    pcap_state_e state_q;
    logic [15:0] block_size_q;
    logic [15:0] smpl_count_q;
    logic [15:0] irq_count_q;
    logic [31:0] total_q;
    logic [31:0] rd_data_q;
    logic        dma_valid_q;
    logic [31:0] dma_addr_q;
    logic [31:0] dma_data_q;
    logic [7:0]  flags_q;
    logic [7:0]  flags_d;
    logic [FLAG_W-1:0] flag_set;
    logic [31:0] rd_mux;
    logic [31:0] base;
    logic [15:0] count_inc;
    logic        arm_wr, disarm_wr, push_wr, irq_rd;
    logic        frame_ok, accept, block_hit;
    logic        fifo_pop, fifo_empty, fifo_full;

    assign arm_wr    = wr_en && (wr_addr == REG_ARM);
    assign disarm_wr = wr_en && (wr_addr == REG_DISARM);
    assign push_wr   = wr_en && (wr_addr == REG_DMA_ADDR);
    assign irq_rd    = rd_en && (rd_addr == REG_IRQ_STATUS);

`ifdef PCAP_FRAMING_EN
    logic [31:0] framing_mask_q;

    assign frame_ok = (framing_mask_q == 32'd0) || ((frame_i & framing_mask_q) != 32'd0);

    always_ff @(posedge FCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            framing_mask_q <= '0;
        end else if (wr_en && (wr_addr == REG_FRAMING_MASK)) begin
            framing_mask_q <= wr_data;
        end
    end
`else
    logic unused_frame;
    assign unused_frame = ^frame_i;
    assign frame_ok     = 1'b1;
`endif

    assign accept    = (state_q == ST_ARMED) && smpl_valid && frame_ok;
    assign count_inc = smpl_count_q + 16'd1;
    assign block_hit = accept && (count_inc >= eff_block_size(block_size_q));
    // A DISARM ends the capture outright, so a block finishing in that cycle takes no new base.
    assign fifo_pop  = ((state_q == ST_IDLE) && arm_wr && !fifo_empty) ||
                       (block_hit && !disarm_wr && !fifo_empty);

    pcap_addr_fifo #(
        .DEPTH (ADDR_DEPTH),
        .W     (32)
    ) u_addr_fifo (
        .clk_i       (FCLK),
        .rst_ni      (ARESETn),
        .push_i      (push_wr),
        .push_data_i (wr_data),
        .pop_i       (fifo_pop),
        .head_o      (base),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_comb begin
        flag_set = '0;
        if ((state_q == ST_IDLE) && arm_wr && fifo_empty) begin
            flag_set[FLAG_NO_ADDR] = 1'b1;
        end
        if (block_hit) begin
            flag_set[FLAG_BLOCK_DONE] = 1'b1;
            if (fifo_empty && !disarm_wr) begin
                flag_set[FLAG_NO_ADDR]   = 1'b1;
                flag_set[FLAG_COMPLETED] = 1'b1;
            end
        end
        if ((state_q == ST_ARMED) && disarm_wr) begin
            flag_set[FLAG_COMPLETED]  = 1'b1;
            flag_set[FLAG_USER_ABORT] = 1'b1;
        end
        if (push_wr && fifo_full) begin
            flag_set[FLAG_TABLE_OVF] = 1'b1;
        end
    end

    // A status read clears only what it returned; flags raised in the same cycle survive.
    for (genvar gi = 0; gi < 8; gi++) begin : g_flag
        if (gi < FLAG_W) begin : g_live
            assign flags_d[gi] = (flags_q[gi] & ~irq_rd) | flag_set[gi];
        end else begin : g_zero
            assign flags_d[gi] = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            REG_BLOCK_SIZE:    rd_mux = {16'h0000, block_size_q};
            REG_IRQ_STATUS:    rd_mux = {irq_count_q, 8'h00, flags_q};
`ifdef PCAP_FRAMING_EN
            REG_FRAMING_MASK:  rd_mux = framing_mask_q;
`endif
            REG_TOTAL_SAMPLES: rd_mux = total_q;
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge FCLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_IDLE;
            block_size_q <= 16'd1;
            smpl_count_q <= '0;
            irq_count_q  <= '0;
            total_q      <= '0;
            rd_data_q    <= '0;
            dma_valid_q  <= 1'b0;
            dma_addr_q   <= '0;
            dma_data_q   <= '0;
            flags_q      <= '0;
        end else begin
            dma_valid_q <= accept;
            if (accept) begin
                dma_addr_q <= base + {14'd0, smpl_count_q, 2'b00};
                dma_data_q <= smpl_data;
                total_q    <= total_q + 32'd1;
            end
            if (wr_en && (wr_addr == REG_BLOCK_SIZE)) begin
                block_size_q <= wr_data[15:0];
            end
            rd_data_q <= rd_en ? rd_mux : 32'd0;
            flags_q   <= flags_d;

            case (state_q)
                ST_IDLE: begin
                    if (arm_wr && !fifo_empty) begin
                        state_q      <= ST_ARMED;
                        smpl_count_q <= '0;
                        total_q      <= '0;
                    end
                end
                ST_ARMED: begin
                    if (accept) begin
                        smpl_count_q <= count_inc;
                    end
                    if (disarm_wr) begin
                        state_q     <= ST_IDLE;
                        irq_count_q <= accept ? count_inc : smpl_count_q;
                    end else if (block_hit) begin
                        irq_count_q <= count_inc;
                        if (fifo_empty) begin
                            state_q <= ST_IDLE;
                        end else begin
                            smpl_count_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign dma_valid  = dma_valid_q;
    assign dma_addr   = dma_addr_q;
    assign dma_data   = dma_data_q;
    assign irq        = |flags_q;
    assign pcap_armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_panda_top_tb_wrap.sv
// Bench for the PCAP control core: hand-written vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_panda_top_tb_wrap;

    localparam int DEPTH = 32;

    logic        FCLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        smpl_valid = 1'b0;
    logic [31:0] smpl_data = '0;
    logic [31:0] frame_i = '0;
    logic        dma_valid;
    logic [31:0] dma_addr;
    logic [31:0] dma_data;
    logic        irq;
    logic        pcap_armed;

    int checks = 0;
    int errors = 0;
    int dma_seen = 0;

    always #5 FCLK = ~FCLK;

    panda_top_tb_wrap #(.ADDR_DEPTH(DEPTH)) dut (
        .FCLK       (FCLK),
        .ARESETn    (ARESETn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .smpl_valid (smpl_valid),
        .smpl_data  (smpl_data),
        .frame_i    (frame_i),
        .dma_valid  (dma_valid),
        .dma_addr   (dma_addr),
        .dma_data   (dma_data),
        .irq        (irq),
        .pcap_armed (pcap_armed)
    );

    // Reference model state: the buffer table is a plain queue.
    int unsigned mq[$];
    bit          m_armed;
    logic [31:0] m_base, m_total, m_mask;
    logic [15:0] m_cnt, m_icnt, m_bs;
    logic [7:0]  m_flags;
    logic [31:0] e_rd, e_da, e_dd;
    logic        e_dv, e_armed, e_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_armed = 1'b0; m_base = '0; m_total = '0; m_mask = '0;
        m_cnt = '0; m_icnt = '0; m_bs = 16'd1; m_flags = '0;
    endtask

    function automatic bit frame_ok(input logic [31:0] fr);
`ifdef PCAP_FRAMING_EN
        return (m_mask == 32'd0) || ((fr & m_mask) != 32'd0);
`else
        return (fr === fr);
`endif
    endfunction

    task automatic model_step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic re, input logic [3:0] ra,
                              input logic sv, input logic [31:0] sd, input logic [31:0] fr);
        bit was_armed;
        int qn;
        int eff;
        bit acc;
        logic [7:0] nf;
        was_armed = m_armed;
        qn = mq.size();
        nf = 8'h00;
        e_rd = 32'd0;
        if (re) begin
            case (ra)
                4'd2: e_rd = {16'h0000, m_bs};
                4'd4: e_rd = {m_icnt, 8'h00, m_flags};
`ifdef PCAP_FRAMING_EN
                4'd5: e_rd = m_mask;
`endif
                4'd6: e_rd = m_total;
                default: e_rd = 32'd0;
            endcase
        end
        eff = (m_bs == 16'd0) ? 1 : int'(m_bs);
        acc = was_armed && sv && frame_ok(fr);
        e_dv = acc;
        if (acc) begin
            e_da = m_base + 32'(4 * int'(m_cnt));
            e_dd = sd;
            m_cnt++;
            m_total++;
        end
        if (was_armed && we && wa == 4'd1) begin
            nf |= 8'h0A;
            if (acc && int'(m_cnt) >= eff) nf |= 8'h01;
            m_icnt = m_cnt;
            m_armed = 1'b0;
        end else if (acc && int'(m_cnt) >= eff) begin
            nf |= 8'h01;
            m_icnt = m_cnt;
            if (qn > 0) begin
                m_base = mq.pop_front();
                m_cnt = '0;
            end else begin
                nf |= 8'h06;
                m_armed = 1'b0;
            end
        end
        if (!was_armed && we && wa == 4'd0) begin
            if (qn > 0) begin
                m_base = mq.pop_front();
                m_cnt = '0;
                m_total = '0;
                m_armed = 1'b1;
            end else begin
                nf |= 8'h04;
            end
        end
        if (we && wa == 4'd3) begin
            if (qn == DEPTH) nf |= 8'h10;
            else mq.push_back(wd);
        end
        if (we && wa == 4'd2) m_bs = wd[15:0];
        if (we && wa == 4'd5) m_mask = wd;
        m_flags = ((re && ra == 4'd4) ? 8'h00 : m_flags) | nf;
        e_armed = m_armed;
        e_irq = (m_flags != 8'h00);
    endtask

    // One clock cycle: drive at the falling edge, sample one cycle later.
    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic re, input logic [3:0] ra,
                        input logic sv, input logic [31:0] sd, input logic [31:0] fr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra;
        smpl_valid = sv; smpl_data = sd; frame_i = fr;
        model_step(we, wa, wd, re, ra, sv, sd, fr);
        @(negedge FCLK);
        chk("dma_valid", {31'd0, dma_valid}, {31'd0, e_dv});
        if (e_dv) begin
            chk("dma_addr", dma_addr, e_da);
            chk("dma_data", dma_data, e_dd);
        end
        if (re) chk("rd_data", rd_data, e_rd);
        chk("pcap_armed", {31'd0, pcap_armed}, {31'd0, e_armed});
        chk("irq", {31'd0, irq}, {31'd0, e_irq});
        if (dma_valid === 1'b1) dma_seen++;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 4'd0, 32'd0, 1'b1, a, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic smp(input logic [31:0] d, input logic [31:0] fr);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, d, fr);
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        smpl_valid = 1'b0; smpl_data = '0; frame_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESETn = 1'b0;
        @(negedge FCLK);
        @(negedge FCLK);
        ARESETn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        sv;
        logic [31:0] sd;
        logic [31:0] exp_rd;
        logic        exp_dv;
        logic [31:0] exp_da;
        logic        exp_armed;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic re, input logic [3:0] ra,
                                input logic sv, input logic [31:0] sd,
                                input logic [31:0] exp_rd, input logic exp_dv,
                                input logic [31:0] exp_da, input logic exp_armed,
                                input logic exp_irq);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.sv = sv; v.sd = sd;
        v.exp_rd = exp_rd; v.exp_dv = exp_dv; v.exp_da = exp_da;
        v.exp_armed = exp_armed; v.exp_irq = exp_irq;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [13];
        // Two 4-sample blocks into bases 0x1000 and 0x2000.
        tbl[0]  = mk(1'b1, 4'd3, 32'h1000, 1'b0, 4'd0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,    1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 4'd3, 32'h2000, 1'b0, 4'd0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,    1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 4'd2, 32'd4,    1'b0, 4'd0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,    1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 4'd0, 32'h0,    1'b0, 4'd0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,    1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD0, 32'h0,        1'b1, 32'h1000, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD1, 32'h0,        1'b1, 32'h1004, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD2, 32'h0,        1'b1, 32'h1008, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD3, 32'h0,        1'b1, 32'h100C, 1'b1, 1'b1);
        tbl[8]  = mk(1'b0, 4'd0, 32'h0,    1'b1, 4'd4, 1'b1, 32'hD4, 32'h00040001, 1'b1, 32'h2000, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD5, 32'h0,        1'b1, 32'h2004, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD6, 32'h0,        1'b1, 32'h2008, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 32'hD7, 32'h0,        1'b1, 32'h200C, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 4'd0, 32'h0,    1'b1, 4'd4, 1'b0, 32'h0,  32'h00040007, 1'b0, 32'h0,    1'b0, 1'b0);

        // Reset state.
        do_reset();
        chk("rst_state", {26'd0, dma_valid, irq, pcap_armed, |dma_addr, |dma_data, |rd_data}, 32'd0);
        rd(4'd2);
        chk("rst_block_size", rd_data, 32'd1);
        rd(4'd6);
        chk("rst_total", rd_data, 32'd0);

        // Table: two full blocks, then exhaustion.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].sv, tbl[i].sd, 32'd0);
            chk($sformatf("tbl%0d_dv", i), {31'd0, dma_valid}, {31'd0, tbl[i].exp_dv});
            if (tbl[i].exp_dv) begin
                chk($sformatf("tbl%0d_addr", i), dma_addr, tbl[i].exp_da);
                chk($sformatf("tbl%0d_data", i), dma_data, tbl[i].sd);
            end
            if (tbl[i].re) chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_armed", i), {31'd0, pcap_armed}, {31'd0, tbl[i].exp_armed});
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
        end

        // ARM with an empty table.
        do_reset();
        wr(4'd0, 32'd0);
        chk("empty_arm_armed", {31'd0, pcap_armed}, 32'd0);
        rd(4'd4);
        chk("empty_arm_status", rd_data, 32'h00000004);
        rd(4'd4);
        chk("empty_arm_status2", rd_data, 32'h00000000);

        // Partial block ended by DISARM.
        do_reset();
        wr(4'd3, 32'h3000);
        wr(4'd2, 32'd10);
        wr(4'd0, 32'd0);
        smp(32'hA0, 32'd0); smp(32'hA1, 32'd0); smp(32'hA2, 32'd0);
        wr(4'd1, 32'd0);
        chk("disarm_armed", {31'd0, pcap_armed}, 32'd0);
        rd(4'd4);
        chk("disarm_status", rd_data, 32'h0003000A);
        rd(4'd6);
        chk("disarm_total", rd_data, 32'd3);

        // Table overflow, then drain every stored base with one-sample blocks.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) wr(4'd3, 32'h10000 + 32'(i * 256));
        rd(4'd4);
        chk("ovf_status", rd_data, 32'h00000010);
        wr(4'd2, 32'd1);
        wr(4'd0, 32'd0);
        dma_seen = 0;
        for (int i = 0; i < DEPTH + 1; i++) smp(32'hB000 + 32'(i), 32'd0);
        chk("ovf_dma_count", 32'(dma_seen), 32'd32);
        chk("ovf_armed_end", {31'd0, pcap_armed}, 32'd0);
        wr(4'd0, 32'd0);
        rd(4'd4);
        chk("ovf_drained_status", rd_data, 32'h00010007);

        // Frame gating.
        do_reset();
        wr(4'd3, 32'h4000);
        wr(4'd2, 32'd16);
        wr(4'd5, 32'd1);
        rd(4'd5);
        wr(4'd0, 32'd0);
        dma_seen = 0;
        smp(32'hC0, 32'd0); smp(32'hC1, 32'd1); smp(32'hC2, 32'd0); smp(32'hC3, 32'd1);
`ifdef PCAP_FRAMING_EN
        chk("framing_dma_count", 32'(dma_seen), 32'd2);
`else
        chk("noframing_dma_count", 32'(dma_seen), 32'd4);
`endif

        // Asynchronous reset in the middle of a capture.
        do_reset();
        wr(4'd3, 32'h5000);
        wr(4'd3, 32'h6000);
        wr(4'd0, 32'd0);
        smp(32'hE0, 32'd0);
        rd(4'd6);
        smp(32'hE1, 32'd0);
        clear_inputs();
        #3 ARESETn = 1'b0;
        #1;
        chk("midrst_outputs", {26'd0, dma_valid, irq, pcap_armed, |dma_addr, |dma_data, |rd_data}, 32'd0);
        @(negedge FCLK);
        ARESETn = 1'b1;
        model_reset();
        wr(4'd0, 32'd0);
        chk("midrst_no_arm", {31'd0, pcap_armed}, 32'd0);
        rd(4'd4);
        chk("midrst_no_addr", rd_data, 32'h00000004);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic        we, re, sv;
            logic [3:0]  wa, ra;
            logic [31:0] wd;
            we = ($urandom_range(0, 99) < 25);
            case ($urandom_range(0, 9))
                0, 1:    wa = 4'd0;
                2:       wa = 4'd1;
                3:       wa = 4'd2;
                4, 5, 6: wa = 4'd3;
                7:       wa = 4'd5;
                default: wa = 4'($urandom_range(4, 7));
            endcase
            if (wa == 4'd2) wd = 32'($urandom_range(0, 5));
            else if (wa == 4'd5) wd = 32'($urandom_range(0, 3));
            else wd = $urandom;
            re = ($urandom_range(0, 99) < 20);
            ra = 4'($urandom_range(0, 15));
            sv = ($urandom_range(0, 99) < 60);
            step(we, wa, wd, re, ra, sv, $urandom, 32'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
